ram_write_ctrl: RTL and testbench
=================================

// Module: ram_write_ctrl
// PURPOSE
//   Upstream write controller for the two-bank (ping-pong) RAM pair.
//   Accepts a valid/ready data stream and produces wr_data, wr_addr,
//   write_strobe and ram_sel for the RAM selector stage.
//   Fills bank 0, then bank 1, alternating. Each bank is reported full to
//   the consumer, and the controller stalls until the consumer releases it.
// PARAMETERS
//   DATA_W  8  data word width
//   ADDR_W  4  bank address width; bank depth = 2**ADDR_W words
// PORTS
//   clk           in   1         rising-edge clock
//   rst           in   1         async active-high reset
//   in_data       in   DATA_W    stream data
//   in_valid      in   1         stream word present
//   in_ready      out  1         controller can accept (combinational)
//   flush         in   1         close current bank early (partial fill)
//   bank_release  in   2         consumer frees bank[b] (one-cycle pulse)
//   wr_data       out  DATA_W    data to RAM
//   wr_addr       out  ADDR_W    address within selected bank
//   write_strobe  out  1         one-cycle write enable
//   ram_sel       out  1         bank of current write (0/1)
//   bank_done     out  2         one-cycle pulse: bank[b] closed and full
//   done_len      out  ADDR_W+1  words in closed bank, valid with bank_done
//   bank_full     out  2         bank[b] owned by consumer
// BEHAVIOUR
//   Reset (async, rst=1): all outputs and registers clear immediately.
//     Clears wr_*, write_strobe, ram_sel, bank_done, done_len, bank_full,
//     internal cur_bank and addr. State goes to FILL.
//   A word is accepted on a clock edge where in_valid & in_ready.
//   in_ready = (state==FILL) & ~rst.
//   Latency 1 from accept to write:
//     - The next cycle carries write_strobe=1, wr_data=in_data,
//       wr_addr=addr, ram_sel=cur_bank.
//     - These outputs are registered together.
//     - ram_sel, wr_addr and wr_data hold their values when no write occurs.
//   Each accept increments addr.
//   Bank close happens when an accept occurs at addr==2**ADDR_W-1, or on
//     flush in FILL with (addr!=0 or accept in the same cycle). On close:
//     - bank_full[cur]<=1.
//     - bank_done[cur] pulses 1 cycle, aligned with that bank's last
//       write_strobe.
//     - done_len = words written (1..2**ADDR_W).
//     - addr<=0 and cur_bank<=~cur_bank.
//   Flush with an accept in the same cycle: the word is written first and
//     counted in done_len.
//   Flush with addr==0 and no accept: ignored.
//   State machine (2 states):
//     - FILL -> WAIT when the bank being entered after a close is
//       bank_full (checked after this cycle's release).
//     - WAIT: in_ready=0. WAIT -> FILL on the cycle after
//       bank_full[cur_bank] clears.
//   bank_release[b]: clears bank_full[b] on the next edge.
//     - Release of a non-full bank is ignored.
//     - Releasing both banks in one cycle is legal.
//     - Release and close on the same bank in the same cycle cannot occur,
//       because the closing bank is never full.
//   in_valid low: no strobe, no state change. Gaps are allowed anywhere.
//   Address wraps only via close; addr never exceeds 2**ADDR_W-1.
// TESTING (DATA_W=8, ADDR_W=4)
//   1. Reset, stream 0x00..0x0F back to back:
//      -> 16 strobes with ram_sel=0, wr_addr 0..15.
//      -> bank_done=2'b01 and done_len=16 with the last strobe.
//      -> bank_full=01. Word 0x10 is written ram_sel=1 addr 0.
//   2. Stream 33 words with no release:
//      -> after word 32, in_ready=0 and bank_full=11.
//      -> pulse bank_release=01: in_ready=1 two cycles later.
//      -> word 33 is written ram_sel=0 addr 0.
//   3. Five words, then flush alone:
//      -> bank_done=01, done_len=5. Next word goes to ram_sel=1 addr 0.
//      -> A second flush at addr 0 gives no bank_done.
//   4. Flush coincident with the 4th accept:
//      -> that word is written at addr 3, done_len=4.
//   5. Assert rst mid-bank between clock edges (addr=7):
//      -> all outputs are 0 before the next edge.
//      -> the first accept after reset is written ram_sel=0 addr 0.
//   6. bank_release=10 while bank 1 is not full:
//      -> no effect on bank_full. in_valid gaps produce no write_strobe.

Source files
------------

// File: rtl/ram_write_ctrl.sv
// ram_write_ctrl
//   Upstream write controller for a two-bank (ping-pong) RAM pair. Words
//   from a valid/ready stream fill bank 0 and then bank 1, alternating.
//   When a bank is closed (it is full, or it is flushed with at least one
//   word in it), it is handed to the consumer. Writing stalls while the
//   next bank is still owned by the consumer.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   in_data       stream data word
//   in_valid      stream word present
//   in_ready      controller can accept a word (combinational)
//   flush         close the current bank early (partial fill)
//   bank_release  consumer frees bank[b] (one-cycle pulse per bit)
//   wr_data       data to RAM
//   wr_addr       address within the selected bank
//   write_strobe  one-cycle write enable
//   ram_sel       bank of the current write (0/1)
//   bank_done     one-cycle pulse: bank[b] closed and handed over
//   done_len      words in the closed bank, valid with bank_done
//   bank_full     bank[b] owned by the consumer
module ram_write_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   input  logic [1:0]        bank_release,
   output logic [DATA_W-1:0] wr_data,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              write_strobe,
   output logic              ram_sel,
   output logic [1:0]        bank_done,
   output logic [ADDR_W:0]   done_len,
   output logic [1:0]        bank_full
);

   typedef enum logic {FILL = 1'b0, WAIT = 1'b1} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_t            state_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic              cur_bank_reg;

   logic              accept;
   logic              close_bank;
   logic [ADDR_W:0]   len_next;
   logic [1:0]        close_onehot;
   logic [1:0]        bank_full_next;

   // Reset gates ready directly so nothing is accepted while it is held.
   assign in_ready = (state_reg == FILL) & ~rst;
   assign accept   = in_valid & in_ready;

   // A bank closes when its last address is written, or on a flush that
   // leaves at least one word in it (a word accepted alongside the flush
   // counts).
   assign close_bank = (accept & (addr_reg == LAST_ADDR)) |
                       (flush & (state_reg == FILL) & ((addr_reg != '0) | accept));

   assign len_next = {1'b0, addr_reg} + {{ADDR_W{1'b0}}, accept};

   // Ownership after this cycle: releases clear, a close sets. The closing
   // bank is never full, so a release and a close never hit the same bit.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_bank
         assign close_onehot[gi]   = close_bank & (cur_bank_reg == gi[0]);
         assign bank_full_next[gi] = (bank_full[gi] & ~bank_release[gi]) | close_onehot[gi];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= FILL;
         addr_reg     <= '0;
         cur_bank_reg <= 1'b0;
         wr_data      <= '0;
         wr_addr      <= '0;
         write_strobe <= 1'b0;
         ram_sel      <= 1'b0;
         bank_done    <= 2'b00;
         done_len     <= '0;
         bank_full    <= 2'b00;
      end else begin
         write_strobe <= accept;
         if (accept) begin
            wr_data <= in_data;
            wr_addr <= addr_reg;
            ram_sel <= cur_bank_reg;
         end

         bank_done <= close_onehot;
         if (close_bank) begin
            done_len <= len_next;
         end

         bank_full <= bank_full_next;

         if (close_bank) begin
            addr_reg     <= '0;
            cur_bank_reg <= ~cur_bank_reg;
         end else if (accept) begin
            addr_reg <= addr_reg + 1'b1;
         end

         case (state_reg)
            FILL: begin
               // Stall if the bank we are about to enter is still owned.
               if (close_bank && bank_full_next[~cur_bank_reg]) begin
                  state_reg <= WAIT;
               end
            end
            WAIT: begin
               if (!bank_full[cur_bank_reg]) begin
                  state_reg <= FILL;
               end
            end
            default: state_reg <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_write_ctrl.sv
module tb_ram_write_ctrl;

   logic       clk;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       flush;
   logic [1:0] bank_release;
   logic [7:0] wr_data;
   logic [3:0] wr_addr;
   logic       write_strobe;
   logic       ram_sel;
   logic [1:0] bank_done;
   logic [4:0] done_len;
   logic [1:0] bank_full;

   int checks_cnt = 0;
   int errors_cnt = 0;

   // Expected writes {ram_sel, wr_addr, wr_data} and closes {bank_done, done_len}.
   logic [31:0] exp_wr_q[$];
   logic [31:0] exp_done_q[$];

   // Transaction-level reference state.
   logic       m_wait;
   logic       m_bank;
   int         m_addr;
   logic [1:0] m_full;

   ram_write_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .flush        (flush),
      .bank_release (bank_release),
      .wr_data      (wr_data),
      .wr_addr      (wr_addr),
      .write_strobe (write_strobe),
      .ram_sel      (ram_sel),
      .bank_done    (bank_done),
      .done_len     (done_len),
      .bank_full    (bank_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_wait = 1'b0;
      m_bank = 1'b0;
      m_addr = 0;
      m_full = 2'b00;
   endtask

   // One clock cycle of stimulus; called at posedge+1, returns at next posedge+1.
   task automatic drive(input logic v, input logic [7:0] d, input logic f, input logic [1:0] r);
      logic       acc;
      logic       cls;
      logic [1:0] nf;
      logic [1:0] onehot;
      logic [3:0] a4;
      int         len;
      check_val("in_ready", {31'd0, in_ready}, {31'd0, ~m_wait});
      in_valid     = v;
      in_data      = d;
      flush        = f;
      bank_release = r;
      acc = v && !m_wait;
      a4  = m_addr[3:0];
      if (acc) exp_wr_q.push_back({19'd0, m_bank, a4, d});
      cls = (acc && m_addr == 15) || (f && !m_wait && (m_addr != 0 || acc));
      len = m_addr + (acc ? 1 : 0);
      nf  = m_full & ~r;
      if (cls) begin
         nf[m_bank] = 1'b1;
         onehot = m_bank ? 2'b10 : 2'b01;
         exp_done_q.push_back({25'd0, onehot, len[4:0]});
      end
      if (!m_wait) begin
         if (cls && nf[~m_bank]) m_wait = 1'b1;
      end else if (!m_full[m_bank]) begin
         m_wait = 1'b0;
      end
      if (cls) begin
         m_addr = 0;
         m_bank = ~m_bank;
      end else if (acc) begin
         m_addr = m_addr + 1;
      end
      m_full = nf;
      @(posedge clk);
      #1;
      in_valid     = 1'b0;
      flush        = 1'b0;
      bank_release = 2'b00;
      $display("cyc v=%0b d=%02h f=%0b rel=%02b -> strobe=%0b sel=%0b addr=%0d data=%02h done=%02b len=%0d full=%02b rdy=%0b",
               v, d, f, r, write_strobe, ram_sel, wr_addr, wr_data, bank_done, done_len, bank_full, in_ready);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_wr_data"}, {24'd0, wr_data}, 32'd0);
      check_val({tag, "_wr_addr"}, {28'd0, wr_addr}, 32'd0);
      check_val({tag, "_strobe"}, {31'd0, write_strobe}, 32'd0);
      check_val({tag, "_ram_sel"}, {31'd0, ram_sel}, 32'd0);
      check_val({tag, "_bank_done"}, {30'd0, bank_done}, 32'd0);
      check_val({tag, "_done_len"}, {27'd0, done_len}, 32'd0);
      check_val({tag, "_bank_full"}, {30'd0, bank_full}, 32'd0);
      check_val({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
   endtask

   // Scoreboard side: compare every write / close the DUT produces.
   always @(negedge clk) begin
      logic [31:0] e;
      if (!rst) begin
         if (write_strobe) begin
            if (exp_wr_q.size() == 0) begin
               check_val("unexpected_strobe", {19'd0, ram_sel, wr_addr, wr_data}, 32'hFFFF_FFFF);
            end else begin
               e = exp_wr_q.pop_front();
               check_val("write", {19'd0, ram_sel, wr_addr, wr_data}, e);
            end
         end
         if (bank_done != 2'b00) begin
            if (exp_done_q.size() == 0) begin
               check_val("unexpected_done", {25'd0, bank_done, done_len}, 32'hFFFF_FFFF);
            end else begin
               e = exp_done_q.pop_front();
               check_val("done", {25'd0, bank_done, done_len}, e);
            end
         end
      end
   end

   initial begin
      rst          = 1'b1;
      in_data      = 8'd0;
      in_valid     = 1'b0;
      flush        = 1'b0;
      bank_release = 2'b00;
      model_reset();
      #3;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 1: fill bank 0 back to back, then first word of bank 1.
      for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0, 2'b00);
      check_val("t1_bank_full", {30'd0, bank_full}, 32'h1);
      drive(1'b1, 8'h10, 1'b0, 2'b00);

      // 2: finish bank 1 with bank 0 unreleased -> stall.
      for (int i = 17; i < 32; i++) drive(1'b1, 8'(i), 1'b0, 2'b00);
      check_val("t2_bank_full", {30'd0, bank_full}, 32'h3);
      check_val("t2_stalled", {31'd0, in_ready}, 32'h0);
      drive(1'b1, 8'h20, 1'b0, 2'b01);
      check_val("t2_rdy_1later", {31'd0, in_ready}, 32'h0);
      drive(1'b1, 8'h20, 1'b0, 2'b00);
      check_val("t2_rdy_2later", {31'd0, in_ready}, 32'h1);
      drive(1'b1, 8'h20, 1'b0, 2'b00);
      drive(1'b0, 8'h00, 1'b0, 2'b10);
      check_val("t2_released", {30'd0, bank_full}, 32'h0);

      // 3: partial bank closed by flush alone, then an ignored flush.
      for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 2'b00);
      drive(1'b0, 8'h00, 1'b1, 2'b00);
      check_val("t3_bank_full", {30'd0, bank_full}, 32'h1);
      drive(1'b0, 8'h00, 1'b1, 2'b00);
      drive(1'b0, 8'h00, 1'b0, 2'b00);

      // 4: flush coincident with the 4th accept into bank 1.
      for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h50 + i), 1'b0, 2'b00);
      drive(1'b1, 8'h53, 1'b1, 2'b00);
      check_val("t4_bank_full", {30'd0, bank_full}, 32'h3);
      check_val("t4_stalled", {31'd0, in_ready}, 32'h0);
      drive(1'b0, 8'h00, 1'b0, 2'b11);
      check_val("t4_both_released", {30'd0, bank_full}, 32'h0);
      drive(1'b0, 8'h00, 1'b0, 2'b00);

      // 5: reset mid-bank, between edges.
      for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'h60 + i), 1'b0, 2'b00);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      model_reset();
      exp_wr_q.delete();
      exp_done_q.delete();
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      drive(1'b1, 8'hA5, 1'b0, 2'b00);

      // 6: release of a non-full bank, and gaps in the stream.
      drive(1'b0, 8'h00, 1'b0, 2'b10);
      check_val("t6_bank_full", {30'd0, bank_full}, 32'h0);
      drive(1'b0, 8'hEE, 1'b0, 2'b00);
      drive(1'b1, 8'hB6, 1'b0, 2'b00);
      drive(1'b0, 8'hEE, 1'b0, 2'b00);
      drive(1'b1, 8'hC7, 1'b0, 2'b00);
      drive(1'b0, 8'h00, 1'b0, 2'b00);
      drive(1'b0, 8'h00, 1'b0, 2'b00);

      check_val("wr_queue_empty", exp_wr_q.size(), 32'd0);
      check_val("done_queue_empty", exp_done_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
